// File: rtl/mips32_issue_scoreboard.sv
// mips32_issue_scoreboard: in-order issue with per-register write-back scoreboard, branch flush and HLT freeze
module mips32_issue_scoreboard #(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int SW = $clog2(WB_LAT + 1);
    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
    state_t state, state_nxt;
    // cnt[0] is never loaded, so R0 can never raise a hazard
    logic [SW-1:0] cnt [32];
    logic [5:0] op;
    logic [4:0] rs, rt, rd, dest;
    logic is_rr, is_rm, use_rs, use_rt, is_hlt, hazard, issue;
    always_comb begin
        op     = in_instr[31:26];
        rs     = in_instr[25:21];
        rt     = in_instr[20:16];
        rd     = in_instr[15:11];
        is_rr  = op <= 6'h05;
        is_rm  = op inside {6'h08, 6'h0A, 6'h0B, 6'h0C};
        use_rs = is_rr | is_rm | (op inside {6'h09, 6'h0D, 6'h0E});
        use_rt = is_rr | (op == 6'h09);
        dest   = is_rr ? rd : is_rm ? rt : 5'd0;
        is_hlt = op == 6'h3F;
        hazard = in_valid & ((use_rs & (cnt[rs] != '0)) | (use_rt & (cnt[rt] != '0)));
    end
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state != HALT)
            state_nxt = (issue & is_hlt) ? HALT : (hazard & ~flush) ? STALL : RUN;
    end
    always_comb begin
        issue    = (state != HALT) & in_valid & ~hazard & ~flush;
        in_ready = issue;
        halted   = state == HALT;
    end
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < 32; i++)
                cnt[i] <= '0;
        end else begin
            out_valid <= issue;
            if (issue)
                out_instr <= in_instr;
            if (hazard & ~flush & (state != HALT) & ~&stall_cnt)
                stall_cnt <= stall_cnt + CNT_W'(1);
            for (int i = 0; i < 32; i++)
                cnt[i] <= (issue && dest != 5'd0 && dest == 5'(i)) ? SW'(WB_LAT)
                                                                   : cnt[i] - SW'(cnt[i] != '0);
        end
    end
endmodule
